// File: rtl/ex_mem_stage.sv
// Execute stage and EX/MEM pipeline register of the 5-stage RV32I core.
//
// Operands come from the ID/EX register. Each operand is forwarded from the
// EX/MEM register (MEM) or from the write-back bus (WB), and MEM has priority.
// The ALU result, or the link value for jumps, is registered together with the
// forwarded rs2 (store data), rd, funct3 and the memory/write-back controls.
// A branch or jump is resolved combinationally and raises a redirect request.
//
// Ports:
//   CLK, RST              clock; asynchronous active-high reset
//   Enable, clr           EX/MEM load enable (low = stall); synchronous bubble insert
//   PC, Add1              instruction PC and PC+4
//   rd1, rd2, ImmGen      register operands and immediate
//   Rs1, Rs2, instr5b     source and destination register indices
//   instr4b               {funct7[5], funct3}
//   ALUOP, ALUSrc, PCRead operation class and operand selects
//   Brach, AddPC          branch/jump flag; select the link value as the result
//   MemRead..RegWrite     controls passed through to MEM
//   wbRd, wbRegWrite, wbData  write-back forwarding source
//   BranchTaken, BranchTarget combinational redirect request
//   o*                    registered EX/MEM outputs
module ex_mem_stage #(
    parameter int unsigned XLEN          = 32,
    parameter bit          RESET_PC_ZERO = 1'b1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            Enable,
    input  logic            clr,
    input  logic [XLEN-1:0] PC,
    input  logic [XLEN-1:0] Add1,
    input  logic [XLEN-1:0] rd1,
    input  logic [XLEN-1:0] rd2,
    input  logic [XLEN-1:0] ImmGen,
    input  logic [4:0]      Rs1,
    input  logic [4:0]      Rs2,
    input  logic [4:0]      instr5b,
    input  logic [3:0]      instr4b,
    input  logic [1:0]      ALUOP,
    input  logic            ALUSrc,
    input  logic            PCRead,
    input  logic            Brach,
    input  logic            AddPC,
    input  logic            MemRead,
    input  logic            MemWrite,
    input  logic            MemtoReg,
    input  logic            RegWrite,
    input  logic [4:0]      wbRd,
    input  logic            wbRegWrite,
    input  logic [XLEN-1:0] wbData,
    output logic            BranchTaken,
    output logic [XLEN-1:0] BranchTarget,
    output logic [XLEN-1:0] oALURes,
    output logic [XLEN-1:0] oStoreData,
    output logic [4:0]      oRd,
    output logic [2:0]      oFunct3,
    output logic            oMemRead,
    output logic            oMemWrite,
    output logic            oMemtoReg,
    output logic            oRegWrite
);

    // Only an all-zero reset state is supported.
    if (!RESET_PC_ZERO) begin : g_bad_reset
        $error("ex_mem_stage: RESET_PC_ZERO must be 1");
    end

    logic [XLEN-1:0] alu_res_q, alu_res_d;
    logic [XLEN-1:0] store_q, store_d;
    logic [4:0]      rd_q, rd_d;
    logic [2:0]      funct3_q, funct3_d;
    logic            mem_read_q, mem_read_d;
    logic            mem_write_q, mem_write_d;
    logic            mem_to_reg_q, mem_to_reg_d;
    logic            reg_write_q, reg_write_d;

    logic [XLEN-1:0] fwd_a, fwd_b, op_a, op_b, sum, alu_res, result;
    logic [2:0]      funct3;
    logic            alt;
    logic [4:0]      shamt;
    logic            cmp_eq, cmp_lt, cmp_ltu, cmp_taken;

    assign funct3 = instr4b[2:0];
    assign alt    = instr4b[3];

    // A load in MEM has no data yet; that case is stalled upstream.
    always_comb begin
        fwd_a = rd1;
        if (reg_write_q && !mem_to_reg_q && rd_q != 5'd0 && rd_q == Rs1) begin
            fwd_a = alu_res_q;
        end else if (wbRegWrite && wbRd != 5'd0 && wbRd == Rs1) begin
            fwd_a = wbData;
        end
        fwd_b = rd2;
        if (reg_write_q && !mem_to_reg_q && rd_q != 5'd0 && rd_q == Rs2) begin
            fwd_b = alu_res_q;
        end else if (wbRegWrite && wbRd != 5'd0 && wbRd == Rs2) begin
            fwd_b = wbData;
        end
    end

    assign op_a  = PCRead ? PC : fwd_a;
    assign op_b  = ALUSrc ? ImmGen : fwd_b;
    assign sum   = op_a + op_b;
    assign shamt = op_b[4:0];

    assign cmp_eq  = (op_a == op_b);
    assign cmp_lt  = ($signed(op_a) < $signed(op_b));
    assign cmp_ltu = (op_a < op_b);

    always_comb begin
        alu_res = sum;
        unique case (ALUOP)
            2'b00: alu_res = sum;
            2'b01: alu_res = op_a - op_b;
            default: begin
                unique case (funct3)
                    // funct7[5] selects SUB only for register-register ops.
                    3'b000: alu_res = (ALUOP == 2'b10 && alt) ? op_a - op_b : sum;
                    3'b001: alu_res = op_a << shamt;
                    3'b010: alu_res = {{(XLEN-1){1'b0}}, cmp_lt};
                    3'b011: alu_res = {{(XLEN-1){1'b0}}, cmp_ltu};
                    3'b100: alu_res = op_a ^ op_b;
                    3'b101: alu_res = alt ? XLEN'($signed(op_a) >>> shamt) : op_a >> shamt;
                    3'b110: alu_res = op_a | op_b;
                    3'b111: alu_res = op_a & op_b;
                    default: alu_res = sum;
                endcase
            end
        endcase
    end

    always_comb begin
        cmp_taken = 1'b0;
        case (funct3)
            3'b000:  cmp_taken = cmp_eq;
            3'b001:  cmp_taken = !cmp_eq;
            3'b100:  cmp_taken = cmp_lt;
            3'b101:  cmp_taken = !cmp_lt;
            3'b110:  cmp_taken = cmp_ltu;
            3'b111:  cmp_taken = !cmp_ltu;
            default: cmp_taken = 1'b0;
        endcase
    end

    // Gating with Enable keeps a stalled branch from redirecting on every stall cycle.
    assign BranchTaken  = Enable && Brach &&
                          (ALUOP == 2'b00 || (ALUOP == 2'b01 && cmp_taken));
    assign BranchTarget = (ALUOP == 2'b01) ? PC + ImmGen : {sum[XLEN-1:1], 1'b0};

    assign result = AddPC ? Add1 : alu_res;

    always_comb begin
        alu_res_d    = alu_res_q;
        store_d      = store_q;
        rd_d         = rd_q;
        funct3_d     = funct3_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_to_reg_d = mem_to_reg_q;
        reg_write_d  = reg_write_q;
        if (clr) begin
            alu_res_d    = '0;
            store_d      = '0;
            rd_d         = '0;
            funct3_d     = '0;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
            reg_write_d  = 1'b0;
        end else if (Enable) begin
            alu_res_d    = result;
            store_d      = fwd_b;
            rd_d         = instr5b;
            funct3_d     = funct3;
            mem_read_d   = MemRead;
            mem_write_d  = MemWrite;
            mem_to_reg_d = MemtoReg;
            reg_write_d  = RegWrite;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            alu_res_q    <= '0;
            store_q      <= '0;
            rd_q         <= '0;
            funct3_q     <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
        end else begin
            alu_res_q    <= alu_res_d;
            store_q      <= store_d;
            rd_q         <= rd_d;
            funct3_q     <= funct3_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            reg_write_q  <= reg_write_d;
        end
    end

    assign oALURes    = alu_res_q;
    assign oStoreData = store_q;
    assign oRd        = rd_q;
    assign oFunct3    = funct3_q;
    assign oMemRead   = mem_read_q;
    assign oMemWrite  = mem_write_q;
    assign oMemtoReg  = mem_to_reg_q;
    assign oRegWrite  = reg_write_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed cases with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_ex_mem_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        Enable, clr;
    logic [31:0] PC, Add1, rd1, rd2, ImmGen, wbData;
    logic [4:0]  Rs1, Rs2, instr5b, wbRd;
    logic [3:0]  instr4b;
    logic [1:0]  ALUOP;
    logic        ALUSrc, PCRead, Brach, AddPC;
    logic        MemRead, MemWrite, MemtoReg, RegWrite, wbRegWrite;
    logic        BranchTaken;
    logic [31:0] BranchTarget, oALURes, oStoreData;
    logic [4:0]  oRd;
    logic [2:0]  oFunct3;
    logic        oMemRead, oMemWrite, oMemtoReg, oRegWrite;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    ex_mem_stage #(.XLEN(32), .RESET_PC_ZERO(1'b1)) dut (
        .CLK(CLK), .RST(RST), .Enable(Enable), .clr(clr), .PC(PC), .Add1(Add1),
        .rd1(rd1), .rd2(rd2), .ImmGen(ImmGen), .Rs1(Rs1), .Rs2(Rs2),
        .instr5b(instr5b), .instr4b(instr4b), .ALUOP(ALUOP), .ALUSrc(ALUSrc),
        .PCRead(PCRead), .Brach(Brach), .AddPC(AddPC), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .wbRd(wbRd), .wbRegWrite(wbRegWrite), .wbData(wbData),
        .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
        .oALURes(oALURes), .oStoreData(oStoreData), .oRd(oRd), .oFunct3(oFunct3),
        .oMemRead(oMemRead), .oMemWrite(oMemWrite), .oMemtoReg(oMemtoReg),
        .oRegWrite(oRegWrite)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_res, m_st;
    logic [4:0]  m_rd;
    logic [2:0]  m_f3;
    logic        m_mr, m_mw, m_mtr, m_rw;

    function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] rf);
        if (m_rw && !m_mtr && m_rd != 0 && m_rd == rs) return m_res;
        if (wbRegWrite && wbRd != 0 && wbRd == rs) return wbData;
        return rf;
    endfunction

    function automatic logic [31:0] opa();
        return PCRead ? PC : fwd(Rs1, rd1);
    endfunction

    function automatic logic [31:0] opb();
        return ALUSrc ? ImmGen : fwd(Rs2, rd2);
    endfunction

    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = int'(a);
        sb = int'(b);
        if (ALUOP == 2'd0) return a + b;
        if (ALUOP == 2'd1) return a - b;
        case (instr4b[2:0])
            3'd0: return (ALUOP == 2'd2 && instr4b[3]) ? a - b : a + b;
            3'd1: return a << b[4:0];
            3'd2: return (sa < sb) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return instr4b[3] ? 32'(sa >>> b[4:0]) : a >> b[4:0];
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic exp_taken();
        int sa, sb;
        logic [31:0] a, b;
        if (!Enable || !Brach) return 1'b0;
        if (ALUOP == 2'd0) return 1'b1;
        if (ALUOP != 2'd1) return 1'b0;
        a = opa();
        b = opb();
        sa = int'(a);
        sb = int'(b);
        case (instr4b[2:0])
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] exp_target();
        if (ALUOP == 2'd1) return PC + ImmGen;
        return (opa() + opb()) & 32'hFFFF_FFFE;
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST || (!RST && clr)) begin
            m_res <= '0; m_st <= '0; m_rd <= '0; m_f3 <= '0;
            m_mr <= 0; m_mw <= 0; m_mtr <= 0; m_rw <= 0;
        end else if (Enable) begin
            m_res <= AddPC ? Add1 : alu_model(opa(), opb());
            m_st  <= fwd(Rs2, rd2);
            m_rd  <= instr5b;
            m_f3  <= instr4b[2:0];
            m_mr  <= MemRead; m_mw <= MemWrite; m_mtr <= MemtoReg; m_rw <= RegWrite;
        end
    end

    // Compare process: every falling edge.
    always @(negedge CLK) begin
        chk("oALURes", oALURes, m_res);
        chk("oStoreData", oStoreData, m_st);
        chk("oRd", 32'(oRd), 32'(m_rd));
        chk("oFunct3", 32'(oFunct3), 32'(m_f3));
        chk("oCtrl", {28'd0, oMemRead, oMemWrite, oMemtoReg, oRegWrite},
            {28'd0, m_mr, m_mw, m_mtr, m_rw});
        chk("BranchTaken", 32'(BranchTaken), 32'(exp_taken()));
        if (Brach && ALUOP[1] == 1'b0) chk("BranchTarget", BranchTarget, exp_target());
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        Enable = 1; clr = 0; PC = 0; Add1 = 0; rd1 = 0; rd2 = 0; ImmGen = 0;
        Rs1 = 0; Rs2 = 0; instr5b = 0; instr4b = 0; ALUOP = 0; ALUSrc = 0;
        PCRead = 0; Brach = 0; AddPC = 0; MemRead = 0; MemWrite = 0;
        MemtoReg = 0; RegWrite = 0; wbRd = 0; wbRegWrite = 0; wbData = 0;
    endtask

    function automatic logic [31:0] rval();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        RST = 1;
        idle_inputs();
        #12;
        chk("reset_res", oALURes, 32'h0);
        chk("reset_taken", 32'(BranchTaken), 32'h0);
        RST = 0;
        tick();

        // R-type SUB
        rd1 = 5; rd2 = 9; ALUOP = 2'b10; instr4b = 4'b1000; RegWrite = 1; instr5b = 3;
        tick();
        chk("sub_res", oALURes, 32'hFFFF_FFFC);
        chk("sub_rd", 32'(oRd), 32'd3);
        chk("sub_rw", 32'(oRegWrite), 32'd1);

        // Async reset between edges
        #2;
        RST = 1;
        #1;
        chk("async_rst_res", oALURes, 32'h0);
        chk("async_rst_rd", 32'(oRd), 32'h0);
        chk("async_rst_rw", 32'(oRegWrite), 32'h0);
        RST = 0;
        tick();

        // Forwarding priority: build oRd=4/oALURes=0x10
        idle_inputs();
        ALUOP = 2'b11; ALUSrc = 1; rd1 = 32'h10; instr5b = 4; RegWrite = 1;
        tick();
        chk("fwd_setup", oALURes, 32'h10);
        rd1 = 0; Rs1 = 4; ImmGen = 1; wbRd = 4; wbRegWrite = 1; wbData = 32'h20;
        tick();
        chk("fwd_mem_prio", oALURes, 32'h11);
        Rs1 = 0;
        tick();
        chk("fwd_x0", oALURes, 32'h1);

        // BLT / BLTU
        idle_inputs();
        rd1 = 32'hFFFF_FFFF; rd2 = 1; ALUOP = 2'b01; Brach = 1; instr4b = 4'b0100;
        PC = 32'h100; ImmGen = 32'hFFFF_FFF0;
        #1;
        chk("blt_taken", 32'(BranchTaken), 32'd1);
        chk("blt_target", BranchTarget, 32'hF0);
        instr4b = 4'b0110;
        #1;
        chk("bltu_taken", 32'(BranchTaken), 32'd0);
        tick();

        // JALR
        idle_inputs();
        rd1 = 32'h2003; ImmGen = 4; ALUSrc = 1; ALUOP = 2'b00; Brach = 1; AddPC = 1;
        Add1 = 32'h44; RegWrite = 1; instr5b = 1;
        #1;
        chk("jalr_taken", 32'(BranchTaken), 32'd1);
        chk("jalr_target", BranchTarget, 32'h2006);
        tick();
        chk("jalr_link", oALURes, 32'h44);

        // Stall then clr
        Enable = 0; Add1 = 32'h99; instr5b = 7;
        #1;
        chk("stall_taken", 32'(BranchTaken), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold_res", oALURes, 32'h44);
            chk("stall_hold_rd", 32'(oRd), 32'd1);
        end
        Enable = 1; clr = 1;
        tick();
        chk("clr_res", oALURes, 32'h0);
        chk("clr_rw", 32'(oRegWrite), 32'h0);
        clr = 0;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            Enable = ($urandom_range(0, 7) != 0);
            clr = ($urandom_range(0, 15) == 0);
            PC = rval(); Add1 = rval(); rd1 = rval(); rd2 = rval(); ImmGen = rval();
            Rs1 = 5'($urandom_range(0, 7)); Rs2 = 5'($urandom_range(0, 7));
            instr5b = 5'($urandom_range(0, 7)); wbRd = 5'($urandom_range(0, 7));
            instr4b = 4'($urandom); ALUOP = 2'($urandom);
            ALUSrc = 1'($urandom); PCRead = ($urandom_range(0, 3) == 0);
            Brach = 1'($urandom); AddPC = ($urandom_range(0, 3) == 0);
            MemRead = 1'($urandom); MemWrite = 1'($urandom);
            MemtoReg = 1'($urandom); RegWrite = 1'($urandom);
            wbRegWrite = 1'($urandom); wbData = rval();
            tick();
        end

        @(negedge CLK);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Execute stage plus EX/MEM pipeline register of the 5-stage RV32I core.
- Consumes the ID/EX register outputs and applies operand forwarding from MEM and WB.
- Performs ALU ops, resolves branches and jumps, and registers results for the Avalon data-memory stage.
- Drives the redirect/flush request back to fetch and ID/EX.

Parameters:
- XLEN, 32, datapath width.
- RESET_PC_ZERO, 1, when 1 all registered outputs reset to 0; no other reset value is supported.

Ports:
- CLK  in  1  clock, rising-edge.
- RST  in  1  reset, asynchronous, active-high; clears every register.
- Enable  in  1  EX/MEM load enable; low = hold, which is a stall.
- clr  in  1  synchronous bubble insert; zeroes EX/MEM register.
- PC  in  XLEN  instruction PC.
- Add1  in  XLEN  PC+4 (link value).
- rd1, rd2  in  XLEN  register-file operands.
- ImmGen  in  XLEN  sign-extended immediate.
- Rs1, Rs2  in  5  source register indices.
- instr5b  in  5  destination register rd.
- instr4b  in  4  {funct7[5], funct3}.
- ALUOP  in  2  00 add/jump, 01 branch compare, 10 R-type, 11 I-type.
- ALUSrc  in  1  operand B = ImmGen.
- PCRead  in  1  operand A = PC.
- Brach  in  1  branch/jump instruction.
- AddPC  in  1  result = Add1 (JAL/JALR link).
- MemRead, MemWrite, MemtoReg, RegWrite  in  1 each  control bits passed through.
- wbRd  in  5  WB destination.
- wbRegWrite  in  1  WB write enable.
- wbData  in  XLEN  WB write value.
- BranchTaken  out  1  combinational redirect request.
- BranchTarget  out  XLEN  combinational redirect address.
- oALURes  out  XLEN  registered ALU/link result.
- oStoreData  out  XLEN  registered forwarded rs2.
- oRd  out  5  registered rd.
- oFunct3  out  3  registered funct3, for load/store sizing.
- oMemRead, oMemWrite, oMemtoReg, oRegWrite  out  1 each  registered controls.

Behaviour:
- Forwarding, operand A: fwdA = oALURes if oRegWrite && !oMemtoReg && oRd!=0 && oRd==Rs1; else wbData if wbRegWrite && wbRd!=0 && wbRd==Rs1; else rd1.
- Forwarding, operand B: fwdB uses the same rule with Rs2/rd2.
- Forwarding priority: MEM over WB. x0 is never forwarded. Load-use hazards are stalled upstream; MEM-stage load data is not forwarded here.
- Operand select: A = PCRead ? PC : fwdA. B = ALUSrc ? ImmGen : fwdB.
- ALU op, ALUOP 00: ADD.
- ALU op, ALUOP 01: SUB; the compare is taken from funct3: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; 010/011 never taken.
- ALU op, ALUOP 10: funct3 000 = ADD, or SUB if funct7[5]; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL, or SRA if funct7[5]; 110 OR; 111 AND.
- ALU op, ALUOP 11: same as 10, except funct3 000 is always ADD; funct7[5] is honoured only for 101 (SRAI).
- Shifts use B[4:0]. SLT/SLTU produce 0/1. All arithmetic wraps modulo 2^XLEN.
- Branch, ALUOP 01 && Brach: BranchTaken = compare result; BranchTarget = PC + ImmGen.
- Jump, ALUOP 00 && Brach: BranchTaken = 1; BranchTarget = ALU sum with bit0 cleared.
- BranchTaken is forced 0 when Brach=0 or Enable=0, so a stalled instruction never redirects twice.
- Result: AddPC ? Add1 : ALU result.
- Register priority each rising edge: RST (async) > clr > Enable > hold.
- RST: all registered outputs 0, i.e. an all-zero NOP bubble.
- clr: all registered outputs 0 at the edge.
- Enable=1: capture result, fwdB into oStoreData, rd, funct3 and the control bits.
- Enable=0, clr=0: all registered outputs hold.
- Latency: one cycle from ID/EX outputs to EX/MEM outputs. BranchTaken/BranchTarget have zero latency.
- Simultaneous clr and Enable: clr wins.
- RST asserted mid-stall: outputs clear immediately, independent of CLK.

Test Plan:
- Reset: assert RST between edges -> all o* = 0 immediately; BranchTaken=0 with Brach=0.
- R-type SUB: rd1=5, rd2=9, ALUOP=10, instr4b=1000, RegWrite=1, rd=3 -> after one edge oALURes=0xFFFFFFFC, oRd=3, oRegWrite=1.
- Forwarding priority: oRd=4 (oALURes=0x10), wbRd=4 (wbData=0x20), Rs1=4, rd1=0, ADDI imm=1 -> next oALURes=0x11. Repeat with Rs1=0 -> 0x1.
- BLT: fwdA=0xFFFFFFFF, fwdB=1, funct3=100, PC=0x100, ImmGen=0xFFFFFFF0 -> BranchTaken=1, BranchTarget=0xF0. With BLTU instead -> BranchTaken=0.
- JALR: rs1=0x2003, imm=4, AddPC=1, Add1=0x44 -> BranchTarget=0x2006, oALURes=0x44.
- Stall/clr: with Enable=0 the outputs hold over 3 edges and BranchTaken=0; then clr=1 with Enable=1 -> outputs all 0.
